// File: rtl/pll_lock_sequencer.sv
// PLL start-up sequencer: holds the PLL in reset, waits for a stable lock,
// then releases core reset; re-sequences on lock loss and parks in FAULT after repeated failures.
module pll_lock_sequencer #(
  parameter int RST_HOLD_CYCLES    = 64,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       restart_req,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [2:0] retry_count,
  output logic [7:0] lock_loss_count
);

  localparam int HW = $clog2(RST_HOLD_CYCLES);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES);

  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    RUN        = 3'd3,
    FAULT      = 3'd4
  } state_t;

  state_t        state_reg;
  logic [HW-1:0] hold_cnt_reg;
  logic [TW-1:0] to_cnt_reg;
  logic [SW-1:0] stab_cnt_reg;
  logic [2:0]    retry_count_reg;
  logic [7:0]    lock_loss_count_reg;
  logic          sync_meta_reg;
  logic          locked_s_reg;

  logic [2:0]    retry_next;
  logic          timeout_hit;
  logic          retries_exhausted;

  always_comb begin
    retry_next        = retry_count_reg + 3'd1;
    timeout_hit       = (to_cnt_reg >= TO_LAST);
    retries_exhausted = (retry_next == RETRY_MAX);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg           <= RESET_HOLD;
      hold_cnt_reg        <= '0;
      to_cnt_reg          <= '0;
      stab_cnt_reg        <= '0;
      retry_count_reg     <= '0;
      lock_loss_count_reg <= '0;
      sync_meta_reg       <= 1'b0;
      locked_s_reg        <= 1'b0;
    end else begin
      sync_meta_reg <= pll_locked;
      locked_s_reg  <= sync_meta_reg;

      if (restart_req) begin
        state_reg       <= RESET_HOLD;
        hold_cnt_reg    <= '0;
        retry_count_reg <= '0;
      end else begin
        case (state_reg)
          RESET_HOLD: begin
            if (hold_cnt_reg == HOLD_LAST) begin
              state_reg  <= WAIT_LOCK;
              to_cnt_reg <= '0;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
          end
          WAIT_LOCK: begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
            if (locked_s_reg) begin
              state_reg    <= STABLE;
              stab_cnt_reg <= '0;
            end else if (timeout_hit) begin
              retry_count_reg <= retry_next;
              hold_cnt_reg    <= '0;
              state_reg       <= retries_exhausted ? FAULT : RESET_HOLD;
            end
          end
          STABLE: begin
            to_cnt_reg   <= to_cnt_reg + 1'b1;
            stab_cnt_reg <= stab_cnt_reg + 1'b1;
            // Reaching RUN beats a coinciding timeout; a timeout beats a lock
            // drop so the attempt can never return to WAIT_LOCK already expired.
            if (locked_s_reg && stab_cnt_reg == STAB_LAST) begin
              state_reg       <= RUN;
              retry_count_reg <= '0;
            end else if (timeout_hit) begin
              retry_count_reg <= retry_next;
              hold_cnt_reg    <= '0;
              state_reg       <= retries_exhausted ? FAULT : RESET_HOLD;
            end else if (!locked_s_reg) begin
              state_reg    <= WAIT_LOCK;
              stab_cnt_reg <= '0;
            end
          end
          RUN: begin
            if (!locked_s_reg) begin
              state_reg    <= RESET_HOLD;
              hold_cnt_reg <= '0;
              if (lock_loss_count_reg != 8'hFF)
                lock_loss_count_reg <= lock_loss_count_reg + 8'd1;
            end
          end
          FAULT: begin
            state_reg <= FAULT;
          end
          default: begin
            state_reg    <= RESET_HOLD;
            hold_cnt_reg <= '0;
          end
        endcase
      end
    end
  end

  // Outputs are pure decodes of registered state, so no input reaches them combinationally.
  assign pll_rst         = (state_reg == RESET_HOLD) || (state_reg == FAULT);
  assign core_rst        = (state_reg != RUN);
  assign ready           = (state_reg == RUN);
  assign fail            = (state_reg == FAULT);
  assign state           = state_reg;
  assign retry_count     = retry_count_reg;
  assign lock_loss_count = lock_loss_count_reg;

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Sequences the main clock PLL.
- Holds the PLL in reset for a fixed time after power-up or restart.
- Waits for lock with a timeout, then requires lock to be continuously stable before releasing core reset.
- On loss of lock, re-sequences the PLL and counts the event; after repeated acquisition failures it parks in a fault state.
- Sits between the PLL wrapper (drives its rst, samples its locked) and core reset distribution. Runs on the PLL reference clock.

Parameters:
RST_HOLD_CYCLES, 64, cycles pll_rst held high per attempt (>=2)
LOCK_TIMEOUT, 65536, cycles allowed from pll_rst release to reaching RUN before the attempt counts as failed
LOCK_STABLE_CYCLES, 1024, consecutive synced-locked cycles required before RUN (>=2)
MAX_RETRIES, 3, failed attempts before FAULT (1..7)

Ports:
refclk  in  1  reference clock, free-running; all logic on rising edge
rst  in  1  synchronous active-high reset
restart_req  in  1  single-cycle request to re-sequence the PLL from scratch
pll_locked  in  1  PLL locked, asynchronous to refclk
pll_rst  out  1  PLL reset, active-high
core_rst  out  1  core reset, active-high
ready  out  1  high only in RUN
fail  out  1  high only in FAULT
state  out  3  current state encoding
retry_count  out  3  failed attempts in current sequence
lock_loss_count  out  8  lock losses observed in RUN, saturating

Behaviour:
- Clock/reset: one clock, refclk; reset is rst, synchronous and active-high.
- Reset values: state=RESET_HOLD(0), pll_rst=1, core_rst=1, ready=0, fail=0, retry_count=0, lock_loss_count=0, all internal counters 0, sync flops 0.
- Lock input: pll_locked passes through a 2-flop synchronizer to locked_s. Only locked_s is used.
- Latency: pll_locked sampled at edge k gives locked_s after edge k+1; the resulting state change happens at edge k+2.
- Outputs are decoded from the state register; no combinational path from inputs:
  - pll_rst=1 in RESET_HOLD and FAULT.
  - core_rst=0 only in RUN.
  - ready = (state==RUN); fail = (state==FAULT).
- Counters: hold_cnt, to_cnt (timeout), stab_cnt. Each clears on entry to the state that uses it.
- RESET_HOLD(0):
  - hold_cnt increments each cycle.
  - When hold_cnt==RST_HOLD_CYCLES-1 -> WAIT_LOCK and to_cnt=0.
  - pll_rst is therefore high for exactly RST_HOLD_CYCLES cycles.
- WAIT_LOCK(1):
  - to_cnt increments.
  - locked_s=1 -> STABLE and stab_cnt=0.
  - Else, when to_cnt==LOCK_TIMEOUT-1: retry_count+1; if the new value equals MAX_RETRIES -> FAULT, else -> RESET_HOLD.
- STABLE(2):
  - to_cnt continues counting; stab_cnt increments.
  - locked_s=0 -> WAIT_LOCK, stab_cnt cleared, to_cnt kept, lock_loss_count unchanged.
  - stab_cnt==LOCK_STABLE_CYCLES-1 with locked_s=1 -> RUN, retry_count=0.
  - Timeout expiry in STABLE is handled as in WAIT_LOCK. If timeout and RUN entry coincide, RUN wins.
- RUN(3): locked_s=0 -> RESET_HOLD and lock_loss_count+1 (saturates at 255). core_rst is high again the cycle the state leaves RUN.
- FAULT(4):
  - pll_rst=1, core_rst=1; state holds indefinitely.
  - Exit only via restart_req or rst. retry_count holds MAX_RETRIES.
- restart_req: in any state -> RESET_HOLD, retry_count=0, hold_cnt=0. It has priority over every other transition in that cycle, including a lock drop in RUN, which is then not counted. lock_loss_count is not cleared.
- restart_req while already in RESET_HOLD restarts the hold period.
- rst asserted at any time, in any state: all reset values on the next edge. rst has priority over restart_req.
- Unused state encodings 5-7 -> RESET_HOLD on the next edge.

Test Plan:
Bench parameters: RST_HOLD_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=3.
1. Normal start: release rst, drive pll_locked=1 ten cycles after pll_rst falls -> pll_rst high exactly 4 cycles; STABLE at k+2; RUN, core_rst=0, ready=1 at edge k+10; retry_count=0.
2. No lock: hold pll_locked=0 -> three cycles of 4 hold + 32 wait; retry_count 1,2,3; then FAULT, fail=1, pll_rst=1, core_rst=1, held for 200 cycles; restart_req -> RESET_HOLD, retry_count=0, fail=0.
3. Glitch: in STABLE at stab_cnt=5, drop pll_locked for 1 cycle -> back to WAIT_LOCK without reaching RUN; RUN only after 8 continuous synced cycles; lock_loss_count stays 0.
4. Loss in RUN: drop pll_locked at edge k -> core_rst=1 and state=RESET_HOLD at edge k+2; lock_loss_count=1; full re-sequence back to RUN.
5. Priority: restart_req in the same cycle RUN sees locked_s=0 -> RESET_HOLD, lock_loss_count unchanged. rst and restart_req together -> reset values.
6. Saturation and reset: force 260 lock losses -> lock_loss_count=255. rst mid-WAIT_LOCK -> every output at its reset value next edge, pll_rst re-held for 4 cycles.
